// File: rtl/rsa_modexp_arbiter.sv
// rsa_modexp_arbiter
// Shares one modular-exponentiation engine between two requesting channels.
// A round-robin choice is made when both channels request in the same idle
// cycle. The granted channel's operands are latched and either handed to the
// engine or short-circuited for the trivial cases exp == 0 and mod < 2. If the
// engine hangs, a WAIT-state watchdog aborts the job.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req0/1                   level requests, held until the matching done
//   base0/1, exp0/1, mod0/1  per-channel operands (W bits)
//   gnt0/1                   channel currently owns the engine
//   done0/1, err0/1          one-cycle completion pulse and its error flag
//   result0/1                per-channel result, held until the next done
//   eng_start                one-cycle engine start pulse
//   eng_base/exp/mod         latched operands presented to the engine
//   eng_finished, eng_result engine completion level and remainder
module rsa_modexp_arbiter #(
   parameter int TIMEOUT = 70000,
   parameter int W       = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic         req1,
   input  logic [W-1:0] base0,
   input  logic [W-1:0] exp0,
   input  logic [W-1:0] mod0,
   input  logic [W-1:0] base1,
   input  logic [W-1:0] exp1,
   input  logic [W-1:0] mod1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         done0,
   output logic         done1,
   output logic         err0,
   output logic         err1,
   output logic [W-1:0] result0,
   output logic [W-1:0] result1,
   output logic         eng_start,
   output logic [W-1:0] eng_base,
   output logic [W-1:0] eng_exp,
   output logic [W-1:0] eng_mod,
   input  logic         eng_finished,
   input  logic [W-1:0] eng_result
);

   localparam int            CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [W-1:0]  W_ZERO   = {W{1'b0}};
   localparam logic [W-1:0]  W_ONE    = {{(W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_WAIT   = 3'd2,
      S_SETTLE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic          rr_q, rr_d;       // channel that wins a simultaneous request
   logic          sel_q, sel_d;     // channel owning the current job
   logic [CW-1:0] cnt_q, cnt_d;     // WAIT cycles elapsed
   logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic          done0_q, done0_d, done1_q, done1_d;
   logic          err0_q, err0_d, err1_q, err1_d;
   logic [W-1:0]  result0_q, result0_d, result1_q, result1_d;
   logic          eng_start_q, eng_start_d;
   logic [W-1:0]  eng_base_q, eng_base_d, eng_exp_q, eng_exp_d, eng_mod_q, eng_mod_d;

   logic          pick_s;
   logic [W-1:0]  op_base_s, op_exp_s, op_mod_s;
   logic          fin_s, fin_err_s, fin_wr_s;
   logic [W-1:0]  fin_val_s;

   // Arbitration choice and operand mux for the channel that would be granted.
   always_comb begin
      pick_s = 1'b0;
      if (req0 && req1) begin
         pick_s = rr_q;
      end else if (req1) begin
         pick_s = 1'b1;
      end else begin
         pick_s = 1'b0;
      end
      if (pick_s) begin
         op_base_s = base1;
         op_exp_s  = exp1;
         op_mod_s  = mod1;
      end else begin
         op_base_s = base0;
         op_exp_s  = exp0;
         op_mod_s  = mod0;
      end
   end

   // Next-state and next-output logic of the job FSM.
   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      sel_d       = sel_q;
      cnt_d       = cnt_q;
      gnt0_d      = gnt0_q;
      gnt1_d      = gnt1_q;
      done0_d     = 1'b0;
      done1_d     = 1'b0;
      err0_d      = err0_q;
      err1_d      = err1_q;
      result0_d   = result0_q;
      result1_d   = result1_q;
      eng_start_d = 1'b0;
      eng_base_d  = eng_base_q;
      eng_exp_d   = eng_exp_q;
      eng_mod_d   = eng_mod_q;
      fin_s       = 1'b0;
      fin_err_s   = 1'b0;
      fin_wr_s    = 1'b0;
      fin_val_s   = W_ZERO;

      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               sel_d      = pick_s;
               gnt0_d     = ~pick_s;
               gnt1_d     = pick_s;
               eng_base_d = op_base_s;
               eng_exp_d  = op_exp_s;
               eng_mod_d  = op_mod_s;
               // The start pulse must already be high during LAUNCH, so it is
               // decided here from the same operands that are being latched.
               eng_start_d = (op_exp_s != W_ZERO) && (op_mod_s[W-1:1] != {(W-1){1'b0}});
               state_d    = S_LAUNCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LAUNCH: begin
            cnt_d = {CW{1'b0}};
            // mod < 2 wins over exp == 0: anything mod 1 is 0.
            if (eng_mod_q[W-1:1] == {(W-1){1'b0}}) begin
               fin_s     = 1'b1;
               fin_err_s = 1'b1;
               fin_wr_s  = 1'b1;
               fin_val_s = W_ZERO;
               state_d   = S_DONE;
            end else if (eng_exp_q == W_ZERO) begin
               fin_s     = 1'b1;
               fin_err_s = 1'b0;
               fin_wr_s  = 1'b1;
               fin_val_s = W_ONE;
               state_d   = S_DONE;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (eng_finished) begin
               state_d = S_SETTLE;
            end else if (cnt_q == CNT_LAST) begin
               fin_s     = 1'b1;
               fin_err_s = 1'b1;
               fin_wr_s  = 1'b0;
               state_d   = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_SETTLE: begin
            fin_s     = 1'b1;
            fin_err_s = 1'b0;
            fin_wr_s  = 1'b1;
            fin_val_s = eng_result;
            state_d   = S_DONE;
         end
         S_DONE: begin
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            rr_d    = ~sel_q;
            state_d = S_IDLE;
         end
         default: begin
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase

      // Completion: done/err/result are loaded on the edge into DONE so they
      // are visible together while the FSM sits in DONE.
      if (fin_s) begin
         if (sel_q) begin
            done1_d = 1'b1;
            err1_d  = fin_err_s;
            if (fin_wr_s) begin
               result1_d = fin_val_s;
            end else begin
               result1_d = result1_q;
            end
         end else begin
            done0_d = 1'b1;
            err0_d  = fin_err_s;
            if (fin_wr_s) begin
               result0_d = fin_val_s;
            end else begin
               result0_d = result0_q;
            end
         end
      end else begin
         done0_d = 1'b0;
         done1_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rr_q        <= 1'b0;
         sel_q       <= 1'b0;
         cnt_q       <= {CW{1'b0}};
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         done0_q     <= 1'b0;
         done1_q     <= 1'b0;
         err0_q      <= 1'b0;
         err1_q      <= 1'b0;
         result0_q   <= W_ZERO;
         result1_q   <= W_ZERO;
         eng_start_q <= 1'b0;
         eng_base_q  <= W_ZERO;
         eng_exp_q   <= W_ZERO;
         eng_mod_q   <= W_ZERO;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         sel_q       <= sel_d;
         cnt_q       <= cnt_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         done0_q     <= done0_d;
         done1_q     <= done1_d;
         err0_q      <= err0_d;
         err1_q      <= err1_d;
         result0_q   <= result0_d;
         result1_q   <= result1_d;
         eng_start_q <= eng_start_d;
         eng_base_q  <= eng_base_d;
         eng_exp_q   <= eng_exp_d;
         eng_mod_q   <= eng_mod_d;
      end
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign done0     = done0_q;
   assign done1     = done1_q;
   assign err0      = err0_q;
   assign err1      = err1_q;
   assign result0   = result0_q;
   assign result1   = result1_q;
   assign eng_start = eng_start_q;
   assign eng_base  = eng_base_q;
   assign eng_exp   = eng_exp_q;
   assign eng_mod   = eng_mod_q;

endmodule

// File: tb/tb_rsa_modexp_arbiter.sv
// Directed testbench for rsa_modexp_arbiter with a behavioural engine model.
module tb_rsa_modexp_arbiter;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0 = 1'b0, req1 = 1'b0;
   logic [W-1:0] base0 = '0, exp0 = '0, mod0 = '0;
   logic [W-1:0] base1 = '0, exp1 = '0, mod1 = '0;
   logic         gnt0, gnt1, done0, done1, err0, err1, eng_start;
   logic [W-1:0] result0, result1, eng_base, eng_exp, eng_mod;
   logic         eng_finished = 1'b0;
   logic [W-1:0] eng_result = '0;

   // engine model controls
   logic         eng_hang  = 1'b0;
   int           eng_delay = 0;
   int           eng_left  = 0;

   int n_cmp = 0;
   int n_mis = 0;

   // monitor counters
   int n_done0 = 0, n_done1 = 0, n_start = 0, n_both_done = 0, n_both_gnt = 0, n_gnt1 = 0;
   logic [W-1:0] st_base = '0, st_exp = '0, st_mod = '0;

   rsa_modexp_arbiter #(.TIMEOUT(20), .W(W)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1),
      .base0(base0), .exp0(exp0), .mod0(mod0),
      .base1(base1), .exp1(exp1), .mod1(mod1),
      .gnt0(gnt0), .gnt1(gnt1),
      .done0(done0), .done1(done1),
      .err0(err0), .err1(err1),
      .result0(result0), .result1(result1),
      .eng_start(eng_start),
      .eng_base(eng_base), .eng_exp(eng_exp), .eng_mod(eng_mod),
      .eng_finished(eng_finished), .eng_result(eng_result)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] mexp(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m);
      logic [31:0] r, x;
      r = 32'd1 % {16'd0, m};
      x = {16'd0, b} % {16'd0, m};
      for (int i = 0; i < W; i++) begin
         if (e[i]) r = (r * x) % {16'd0, m};
         x = (x * x) % {16'd0, m};
      end
      return r[W-1:0];
   endfunction

   // Engine model: finished drops on start and rises eng_delay cycles later.
   always @(posedge clk) begin
      if (eng_start) begin
         eng_result   <= mexp(eng_base, eng_exp, eng_mod);
         eng_finished <= (eng_delay == 0);
         eng_left     <= eng_delay;
      end else if (!eng_hang && eng_left != 0) begin
         eng_left <= eng_left - 1;
         if (eng_left == 1) eng_finished <= 1'b1;
      end
   end

   // Output monitor.
   always @(negedge clk) begin
      if (done0) n_done0 <= n_done0 + 1;
      if (done1) n_done1 <= n_done1 + 1;
      if (done0 && done1) n_both_done <= n_both_done + 1;
      if (gnt0 && gnt1) n_both_gnt <= n_both_gnt + 1;
      if (gnt1) n_gnt1 <= n_gnt1 + 1;
      if (eng_start) begin
         n_start <= n_start + 1;
         st_base <= eng_base;
         st_exp  <= eng_exp;
         st_mod  <= eng_mod;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_mis++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until the given channel's done is high; k = cycles taken, 0 if never.
   task automatic wait_done(input logic ch, input int max_cyc, output int k);
      int i;
      i = 0;
      k = 0;
      while (k == 0 && i < max_cyc) begin
         i++;
         tick();
         if ((ch ? done1 : done0) === 1'b1) k = i;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k, s0, d0, d1, g1;

      // ---- reset values
      tick(); tick();
      check("rst_gnt0", gnt0, 1'b0);
      check("rst_gnt1", gnt1, 1'b0);
      check("rst_done", {done0, done1}, 2'b00);
      check("rst_err", {err0, err1}, 2'b00);
      check("rst_eng_start", eng_start, 1'b0);
      check("rst_result0", result0, 16'd0);
      check("rst_eng_ops", {eng_base, eng_exp, eng_mod}, 48'd0);
      rst = 1'b0;
      tick();

      // ---- basic engine job on channel 0: 5^3 mod 33 = 26
      eng_delay = 0;
      g1 = n_gnt1;
      s0 = n_start;
      base0 = 16'd5; exp0 = 16'd3; mod0 = 16'd33; req0 = 1'b1;
      wait_done(1'b0, 20, k);
      check("basic_latency", k, 4);
      check("basic_result0", result0, 16'd26);
      check("basic_err0", err0, 1'b0);
      check("basic_start_cnt", n_start - s0, 1);
      check("basic_start_ops", {st_base, st_exp, st_mod}, {16'd5, 16'd3, 16'd33});
      check("basic_eng_hold", {eng_base, eng_exp, eng_mod}, {16'd5, 16'd3, 16'd33});
      req0 = 1'b0;
      tick();
      check("basic_gnt0_drop", gnt0, 1'b0);
      tick();
      check("basic_no_gnt1", n_gnt1 - g1, 0);

      // ---- round robin after reset: channel 0 first
      rst = 1'b1;
      tick();
      rst = 1'b0;
      base0 = 16'd7; exp0 = 16'd5; mod0 = 16'd101;
      base1 = 16'd3; exp1 = 16'd4; mod1 = 16'd50;
      req0 = 1'b1; req1 = 1'b1;
      d1 = n_done1;
      wait_done(1'b0, 20, k);
      check("rr_first_ch0", k != 0, 1'b1);
      check("rr_ch0_result", result0, 16'd41);
      check("rr_ch1_not_yet", n_done1 - d1, 0);
      req0 = 1'b0;
      wait_done(1'b1, 20, k);
      check("rr_then_ch1", k != 0, 1'b1);
      check("rr_ch1_result", result1, 16'd31);
      req1 = 1'b0;
      tick();
      // channel 0 alone, so it is the last served: 2^10 mod 1000 = 24
      base0 = 16'd2; exp0 = 16'd10; mod0 = 16'd1000; req0 = 1'b1;
      wait_done(1'b0, 20, k);
      check("rr_solo_ch0", result0, 16'd24);
      req0 = 1'b0;
      tick();
      // simultaneous pair now favours channel 1
      base0 = 16'd7; exp0 = 16'd5; mod0 = 16'd101;
      req0 = 1'b1; req1 = 1'b1;
      d0 = n_done0;
      wait_done(1'b1, 20, k);
      check("rr_pair_ch1_first", k != 0, 1'b1);
      check("rr_pair_no_done0", n_done0 - d0, 0);
      req1 = 1'b0;
      wait_done(1'b0, 20, k);
      check("rr_pair_ch0_result", result0, 16'd41);
      req0 = 1'b0;
      tick();

      // ---- trivial jobs skip the engine
      s0 = n_start;
      base1 = 16'd9; exp1 = 16'd0; mod1 = 16'd33; req1 = 1'b1;
      wait_done(1'b1, 10, k);
      check("exp0_latency", k, 2);
      check("exp0_result1", result1, 16'd1);
      check("exp0_err1", err1, 1'b0);
      req1 = 1'b0;
      tick();
      exp1 = 16'd5; mod1 = 16'd1; req1 = 1'b1;
      wait_done(1'b1, 10, k);
      check("mod1_latency", k, 2);
      check("mod1_result1", result1, 16'd0);
      check("mod1_err1", err1, 1'b1);
      req1 = 1'b0;
      tick();
      check("skip_no_start", n_start - s0, 0);

      // ---- engine hang: timeout after 20 WAIT cycles, req dropped mid-job
      eng_hang = 1'b1; eng_delay = 5;
      s0 = n_start;
      base0 = 16'd5; exp0 = 16'd3; mod0 = 16'd33; req0 = 1'b1;
      tick();
      req0 = 1'b0;
      wait_done(1'b0, 60, k);
      check("timeout_latency", k + 1, 22);
      check("timeout_err0", err0, 1'b1);
      check("timeout_result0_kept", result0, 16'd41);
      check("timeout_start_cnt", n_start - s0, 1);
      tick(); tick();

      // ---- reset during WAIT discards the job, then relaunch
      req0 = 1'b1;
      tick(); tick(); tick(); tick();
      check("midjob_gnt0", gnt0, 1'b1);
      d0 = n_done0;
      s0 = n_start;
      rst = 1'b1;
      #1;
      check("midrst_gnt0", gnt0, 1'b0);
      check("midrst_result0", result0, 16'd0);
      check("midrst_eng_ops", {eng_base, eng_exp, eng_mod}, 48'd0);
      tick(); tick();
      eng_hang = 1'b0; eng_delay = 2;
      rst = 1'b0;
      wait_done(1'b0, 30, k);
      check("relaunch_done", k != 0, 1'b1);
      check("relaunch_no_stale_done", n_done0 - d0, 0);
      check("relaunch_fresh_start", n_start - s0, 1);
      check("relaunch_result0", result0, 16'd26);
      check("relaunch_err0", err0, 1'b0);
      req0 = 1'b0;
      tick(); tick();

      check("never_both_done", n_both_done, 0);
      check("never_both_gnt", n_both_gnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/rsa_modexp_arbiter.md
RSA_MODEXP_ARBITER -- requirements
Module: rsa_modexp_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- TIMEOUT, default 70000, WAIT-state cycle limit before abort.
- W, default 16, operand/result width.

REQ-002 The block SHALL have these ports, one clock, asynchronous active-high reset:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0, req1  in  1  level request; held high until matching done pulse.
- base0, exp0, mod0  in  W  channel-0 operands, stable while req0 high.
- base1, exp1, mod1  in  W  channel-1 operands, stable while req1 high.
- gnt0, gnt1  out  1  channel currently owns the engine.
- done0, done1  out  1  one-cycle job-complete pulse.
- err0, err1  out  1  valid with done; job aborted or rejected.
- result0, result1  out  W  result; held until that channel's next done.
- eng_start  out  1  one-cycle start pulse to the mod-exp engine.
- eng_base, eng_exp, eng_mod  out  W  latched operands to the engine.
- eng_finished  in  1  engine completion level.
- eng_result  in  W  engine remainder output.

Function
REQ-003 The block SHALL be an FSM with states IDLE, LAUNCH, WAIT, SETTLE, DONE, and at most one granted channel at any time.
REQ-004 In IDLE with exactly one req high, the block SHALL grant that channel; with both high, it SHALL grant the channel not served last. The round-robin pointer starts at channel 0 after reset.
REQ-005 On grant, the block SHALL latch that channel's base, exp and mod into internal registers, assert its gnt, and enter LAUNCH the next cycle.
REQ-006 If latched exp == 0, the block SHALL skip the engine, go LAUNCH->DONE, and return result 1 with err 0.
REQ-007 If latched mod < 2, the block SHALL skip the engine, go LAUNCH->DONE, and return result 0 with err 1.
REQ-008 Otherwise, in LAUNCH the block SHALL drive eng_start=1 for exactly one cycle with eng_base/eng_exp/eng_mod from the latched registers, then enter WAIT.
REQ-009 eng_base/eng_exp/eng_mod SHALL hold the latched values from LAUNCH through SETTLE.
REQ-010 eng_finished SHALL be ignored during the LAUNCH cycle.
REQ-011 In WAIT, eng_finished=1 SHALL move the FSM to SETTLE.
REQ-012 In SETTLE (one cycle), the block SHALL capture eng_result into the granted channel's result register and enter DONE.
REQ-013 A WAIT cycle counter SHALL clear on LAUNCH; when it reaches TIMEOUT without eng_finished, the block SHALL go to DONE with err=1 and result unchanged.
REQ-014 In DONE, the block SHALL pulse the granted channel's done for one cycle, drop gnt, update the round-robin pointer, and return to IDLE.
REQ-015 A req still high in the IDLE cycle after DONE SHALL be treated as a new job.
REQ-016 Minimum engine-path latency SHALL be grant edge -> done: LAUNCH + WAIT(>=1) + SETTLE + DONE = 4 cycles after IDLE sampling.
REQ-017 A req dropped while granted SHALL NOT abort the job; done still pulses.
REQ-018 done0 and done1 SHALL never be high in the same cycle.
REQ-019 All outputs SHALL be registered.

Reset
REQ-020 rst high SHALL asynchronously force:
- state IDLE, RR pointer to channel 0, TIMEOUT counter 0;
- gnt0/1, done0/1, err0/1, eng_start all 0;
- result0/1, eng_base/exp/mod all 0.
REQ-021 rst asserted mid-job (any state) SHALL discard the job without a done pulse; after release, requests still high SHALL be re-arbitrated from IDLE.

Verification
REQ-022 req0, base0=5, exp0=3, mod0=33, engine model -> one eng_start with 5/3/33; done0 with result0=26, err0=0; gnt1 never high.
REQ-023 req0 and req1 both high in the same IDLE cycle after reset -> channel 0 is served first, then channel 1; next simultaneous pair is served channel 1 first only if channel 0 was last.
REQ-024 req1, exp1=0, mod1=33 -> no eng_start; done1 two cycles after grant with result1=1, err1=0. Repeat with mod1=1 -> result1=0, err1=1.
REQ-025 Engine model that never asserts eng_finished, TIMEOUT=20 -> done0 with err0=1 exactly 20 WAIT cycles after LAUNCH; result0 unchanged.
REQ-026 rst pulse during WAIT of a channel-0 job -> outputs take reset values immediately, no done0; with req0 still high after release, the job relaunches with a fresh eng_start.
